alu_vector_checker: RTL and testbench
=====================================

Name: alu_vector_checker

Overview:
- Synthesisable, parametrised self-checking vector engine for combinational or pipelined ALUs.
- Holds DEPTH test vectors in an internal memory. Each vector is {f, a, b, y_expected, zero_expected}.
- Loaded through a write port. On start, drives each vector onto the DUT, waits DUT_LATENCY cycles, then compares y and zero.
- Reports error count, first failing index and a pass flag. Sits beside the ALU on the lab board/sim top level, replacing file-driven benches.

Parameters:
- WIDTH, 32, data width of a, b, y.
- FWIDTH, 3, ALU function-select width.
- DEPTH, 32, vector memory entries (power of two).
- AW, 5, address width, log2(DEPTH).
- DUT_LATENCY, 0, cycles from operand apply to valid DUT result (0 = combinational).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- vec_we  in  1  write strobe for vector memory.
- vec_addr  in  AW  write address.
- vec_wdata  in  FWIDTH+3*WIDTH+1  packed vector {f, a, b, y_exp, zero_exp}, f in MSBs.
- num_vectors  in  AW+1  vectors to run, 0..DEPTH; sampled on start.
- start  in  1  one-cycle pulse; begins a run.
- dut_f  out  FWIDTH  function select to DUT.
- dut_a  out  WIDTH  operand a to DUT.
- dut_b  out  WIDTH  operand b to DUT.
- dut_y  in  WIDTH  DUT result.
- dut_zero  in  1  DUT zero flag.
- busy  out  1  run in progress.
- done  out  1  high from end of run until next start or reset.
- pass  out  1  valid when done; 1 if err_count==0.
- err_count  out  AW+1  mismatching vectors this run.
- first_fail  out  AW  index of first mismatch; valid when err_count!=0.
- cur_index  out  AW  vector currently applied.

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE. Reset does not clear vector memory.
- Memory write: when vec_we=1, write in that cycle. Allowed in any state. A write to the entry being applied is undefined; the bench must not do this.
- IDLE/DONE, start=1 and num_vectors==0: go to DONE next cycle; pass=1, err_count=0.
- IDLE/DONE, start=1 and num_vectors>0: latch count, clear err_count/first_fail/done, set idx=0, go to APPLY.
- start while busy: ignored.
- APPLY:
  - dut_f/a/b take mem[idx] on the next edge and hold until the next APPLY.
  - Load wait counter with DUT_LATENCY.
  - Go to WAIT if DUT_LATENCY>0, else CHECK.
- WAIT: decrement counter each cycle; go to CHECK when it reaches 1.
- CHECK:
  - Mismatch = (dut_y != y_exp) OR (dut_zero != zero_exp).
  - On mismatch: err_count saturates at all-ones (no wrap). first_fail=idx only if err_count was 0.
  - If idx==count-1: go to DONE. Otherwise idx+1, go to APPLY.
- Cycles per vector: 2+DUT_LATENCY (APPLY+CHECK+WAIT).
- DONE: busy=0, done=1, pass=(err_count==0). Hold until start or reset.
- busy=1 in APPLY, WAIT and CHECK.
- cur_index mirrors idx.
- Reset mid-run: abort next edge; outputs return to reset values.
- idx widths: idx never exceeds DEPTH-1; num_vectors>DEPTH clamps to DEPTH.

Optional Feature:
- Macro ALU_CHECK_STOP_ON_FAIL_EN.
- Defined: first mismatch in CHECK goes straight to DONE. err_count=1, first_fail=cur_index=failing idx, dut_* hold the failing operands for debug.
- Undefined: run always completes all num_vectors vectors.

Test Plan:
- Load 4 vectors for a correct 32-bit ALU (f=2 add 5+3=8 z0; f=6 sub 7-7=0 z1; f=0 and FFFF0000&0F0F0F0F=0F0F0000 z0; f=7 slt 1<2=1 z0), num_vectors=4, start -> done after 8 cycles (latency 0), pass=1, err_count=0.
- Same set with vector 2 y_exp corrupted to 0F0F0001 -> err_count=1, first_fail=2, pass=0. With ALU_CHECK_STOP_ON_FAIL_EN: done after 6 cycles, cur_index=2, dut_a=FFFF0000.
- num_vectors=0, start -> done=1 and pass=1 one cycle later; dut_* remain 0.
- DUT_LATENCY=2 with registered ALU, 4 good vectors -> done after 16 cycles, pass=1. Also: start pulsed again at cycle 3 -> ignored.
- Reset asserted in cycle 5 of a run -> busy=0, done=0, err_count=0, dut_*=0 next cycle. Start again -> same results as an uninterrupted run (memory retained).
- DEPTH=32, all 32 vectors wrong, plus num_vectors=33 -> clamped to 32 vectors; err_count=32, first_fail=0.

Source files
------------

// File: rtl/alu_vector_checker_if.sv
// Bundles the vector-load, run-control, ALU-drive and status signals of alu_vector_checker.
// master = board/bench side (loads vectors, feeds ALU results back); slave = the checker.
interface alu_vector_checker_if #(
    parameter int WIDTH  = 32,
    parameter int FWIDTH = 3,
    parameter int AW     = 5
);
    logic                        vec_we;
    logic [AW-1:0]               vec_addr;
    logic [FWIDTH+3*WIDTH:0]     vec_wdata;
    logic [AW:0]                 num_vectors;
    logic                        start;
    logic [FWIDTH-1:0]           dut_f;
    logic [WIDTH-1:0]            dut_a;
    logic [WIDTH-1:0]            dut_b;
    logic [WIDTH-1:0]            dut_y;
    logic                        dut_zero;
    logic                        busy;
    logic                        done;
    logic                        pass;
    logic [AW:0]                 err_count;
    logic [AW-1:0]               first_fail;
    logic [AW-1:0]               cur_index;

    modport master (
        output vec_we, vec_addr, vec_wdata, num_vectors, start, dut_y, dut_zero,
        input  dut_f, dut_a, dut_b, busy, done, pass, err_count, first_fail, cur_index
    );

    modport slave (
        input  vec_we, vec_addr, vec_wdata, num_vectors, start, dut_y, dut_zero,
        output dut_f, dut_a, dut_b, busy, done, pass, err_count, first_fail, cur_index
    );
endinterface

// File: rtl/alu_vector_checker.sv
// Self-checking ALU vector engine; ALU_CHECK_STOP_ON_FAIL_EN stops the run at the first mismatch.
// Latency: 2+DUT_LATENCY cycles per vector after the start edge; num_vectors==0 finishes on the start edge.
// Backpressure: none; start is ignored while busy, memory writes are accepted in any state.
module alu_vector_checker #(
    parameter int WIDTH       = 32,
    parameter int FWIDTH      = 3,
    parameter int DEPTH       = 32,
    parameter int AW          = 5,
    parameter int DUT_LATENCY = 0
) (
    input logic              clk,
    input logic              reset,
    alu_vector_checker_if.slave io
);
    localparam int LW = (DUT_LATENCY < 2) ? 1 : $clog2(DUT_LATENCY + 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef struct packed {
        logic [FWIDTH-1:0] f;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [WIDTH-1:0]  y;
        logic              zero;
    } vec_t;

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

    vec_t              mem [DEPTH];
    vec_t              curVec;
    state_t            state;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     lastIdx;
    logic [LW-1:0]     waitCnt;
    logic [AW:0]       errCount;
    logic [AW-1:0]     firstFail;
    logic [FWIDTH-1:0] dutF;
    logic [WIDTH-1:0]  dutA;
    logic [WIDTH-1:0]  dutB;
    logic              busyR;
    logic              doneR;
    logic              passR;

    logic              mismatch;
    logic [AW:0]       errInc;
    logic [AW:0]       errNext;
    logic [AW:0]       numClamped;
    logic [AW:0]       lastClamped;

    // Vector memory survives reset so a run can be repeated after an abort.
    always_ff @(posedge clk) begin
        if (io.vec_we) begin
            mem[io.vec_addr] <= vec_t'(io.vec_wdata);
        end
    end

    assign curVec      = mem[idx];
    assign mismatch    = (io.dut_y != curVec.y) || (io.dut_zero != curVec.zero);
    assign errInc      = (&errCount) ? errCount : errCount + ONE_C;
    assign errNext     = mismatch ? errInc : errCount;
    assign numClamped  = (io.num_vectors > DEPTH_C) ? DEPTH_C : io.num_vectors;
    assign lastClamped = numClamped - ONE_C;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            lastIdx   <= '0;
            waitCnt   <= '0;
            errCount  <= '0;
            firstFail <= '0;
            dutF      <= '0;
            dutA      <= '0;
            dutB      <= '0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            passR     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (io.start) begin
                        errCount  <= '0;
                        firstFail <= '0;
                        idx       <= '0;
                        if (io.num_vectors == '0) begin
                            state <= DONE;
                            doneR <= 1'b1;
                            passR <= 1'b1;
                        end else begin
                            state   <= APPLY;
                            lastIdx <= lastClamped[AW-1:0];
                            busyR   <= 1'b1;
                            doneR   <= 1'b0;
                            passR   <= 1'b0;
                        end
                    end
                end
                APPLY: begin
                    dutF    <= curVec.f;
                    dutA    <= curVec.a;
                    dutB    <= curVec.b;
                    waitCnt <= LW'(DUT_LATENCY);
                    state   <= (DUT_LATENCY > 0) ? WAIT : CHECK;
                end
                WAIT: begin
                    waitCnt <= waitCnt - LW'(1);
                    if (waitCnt == LW'(1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    errCount <= errNext;
                    if (mismatch && (errCount == '0)) begin
                        firstFail <= idx;
                    end
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
                    if (mismatch || (idx == lastIdx)) begin
`else
                    if (idx == lastIdx) begin
`endif
                        state <= DONE;
                        busyR <= 1'b0;
                        doneR <= 1'b1;
                        passR <= (errNext == '0);
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.dut_f      = dutF;
    assign io.dut_a      = dutA;
    assign io.dut_b      = dutB;
    assign io.busy       = busyR;
    assign io.done       = doneR;
    assign io.pass       = passR;
    assign io.err_count  = errCount;
    assign io.first_fail = firstFail;
    assign io.cur_index  = idx;
endmodule

// File: tb/tb_alu_vector_checker.sv
// Directed bench: a combinational-ALU checker instance (latency 0) and a two-stage registered-ALU instance (latency 2).
module tb_alu_vector_checker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_vector_checker_if io0 ();
    alu_vector_checker_if io2 ();

    alu_vector_checker #(.DUT_LATENCY(0)) dut0 (.clk(clk), .reset(reset), .io(io0));
    alu_vector_checker #(.DUT_LATENCY(2)) dut2 (.clk(clk), .reset(reset), .io(io2));

    function automatic logic [31:0] aluOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return a - b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign io0.dut_y    = aluOp(io0.dut_f, io0.dut_a, io0.dut_b);
    assign io0.dut_zero = (io0.dut_y == 32'd0);

    logic [31:0] pipe1, pipe2;
    always_ff @(posedge clk) begin
        pipe1 <= aluOp(io2.dut_f, io2.dut_a, io2.dut_b);
        pipe2 <= pipe1;
    end
    assign io2.dut_y    = pipe2;
    assign io2.dut_zero = (pipe2 == 32'd0);

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        z;
    } tv_t;

    typedef struct {
        int          num;
        int          corrY;
        int          corrZ;
        int          cycles;
        int          err;
        int          first;
        bit          pass;
        int          cur;
        logic [31:0] dutA;
        logic [2:0]  dutF;
    } sc_t;

    tv_t base [4];
    sc_t sc [6];
    int  passCnt = 0;
    int  totalCnt = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wr(input int addr, input tv_t v, input bit to2);
        io0.vec_we    = 1'b1;
        io0.vec_addr  = 5'(addr);
        io0.vec_wdata = {v.f, v.a, v.b, v.y, v.z};
        if (to2) begin
            io2.vec_we    = 1'b1;
            io2.vec_addr  = 5'(addr);
            io2.vec_wdata = {v.f, v.a, v.b, v.y, v.z};
        end
        tick();
        io0.vec_we = 1'b0;
        io2.vec_we = 1'b0;
    endtask

    task automatic loadSet(input int corrY, input int corrZ);
        for (int i = 0; i < 4; i++) begin
            tv_t v;
            v = base[i];
            if (i == corrY) v.y = v.y ^ 32'd1;
            if (i == corrZ) v.z = ~v.z;
            wr(i, v, 1'b0);
        end
    endtask

    task automatic runSc(input string name, input sc_t s, input bit doLoad);
        int cyc;
        if (doLoad) loadSet(s.corrY, s.corrZ);
        io0.num_vectors = 6'(s.num);
        io0.start = 1'b1;
        tick();
        io0.start = 1'b0;
        chk({name, " busy@start"}, 64'(io0.busy), 64'(1));
        chk({name, " done@start"}, 64'(io0.done), 64'(0));
        cyc = 0;
        while (!io0.done && cyc < 300) begin
            tick();
            cyc++;
        end
        chk({name, " cycles"}, 64'(cyc), 64'(s.cycles));
        chk({name, " err_count"}, 64'(io0.err_count), 64'(s.err));
        if (s.err != 0) chk({name, " first_fail"}, 64'(io0.first_fail), 64'(s.first));
        chk({name, " pass"}, 64'(io0.pass), 64'(s.pass));
        chk({name, " busy"}, 64'(io0.busy), 64'(0));
        chk({name, " cur_index"}, 64'(io0.cur_index), 64'(s.cur));
        chk({name, " dut_a"}, 64'(io0.dut_a), 64'(s.dutA));
        chk({name, " dut_f"}, 64'(io0.dut_f), 64'(s.dutF));
    endtask

    initial begin
        int cyc;
        base[0] = '{3'd2, 32'd5,         32'd3,         32'd8,         1'b0};
        base[1] = '{3'd6, 32'd7,         32'd7,         32'd0,         1'b1};
        base[2] = '{3'd0, 32'hFFFF0000,  32'h0F0F0F0F,  32'h0F0F0000,  1'b0};
        base[3] = '{3'd7, 32'd1,         32'd2,         32'd1,         1'b0};
        //          num corrY corrZ cyc err first pass cur dutA         dutF
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
        sc[0] = '{4, -1, -1,  8,  0, 0, 1'b1,  3, 32'd1,        3'd7};
        sc[1] = '{4,  2, -1,  6,  1, 2, 1'b0,  2, 32'hFFFF0000, 3'd0};
        sc[2] = '{2,  2, -1,  4,  0, 0, 1'b1,  1, 32'd7,        3'd6};
        sc[3] = '{4,  0, -1,  2,  1, 0, 1'b0,  0, 32'd5,        3'd2};
        sc[4] = '{4, -1,  1,  4,  1, 1, 1'b0,  1, 32'd7,        3'd6};
        sc[5] = '{33, -1, -1, 2,  1, 0, 1'b0,  0, 32'd0,        3'd2};
`else
        sc[0] = '{4, -1, -1,  8,  0, 0, 1'b1,  3, 32'd1,        3'd7};
        sc[1] = '{4,  2, -1,  8,  1, 2, 1'b0,  3, 32'd1,        3'd7};
        sc[2] = '{2,  2, -1,  4,  0, 0, 1'b1,  1, 32'd7,        3'd6};
        sc[3] = '{4,  0, -1,  8,  1, 0, 1'b0,  3, 32'd1,        3'd7};
        sc[4] = '{4, -1,  1,  8,  1, 1, 1'b0,  3, 32'd1,        3'd7};
        sc[5] = '{33, -1, -1, 64, 32, 0, 1'b0, 31, 32'd31,      3'd2};
`endif
        io0.vec_we = 1'b0; io0.vec_addr = '0; io0.vec_wdata = '0; io0.num_vectors = '0; io0.start = 1'b0;
        io2.vec_we = 1'b0; io2.vec_addr = '0; io2.vec_wdata = '0; io2.num_vectors = '0; io2.start = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("reset busy", 64'(io0.busy), 64'(0));
        chk("reset done", 64'(io0.done), 64'(0));
        chk("reset pass", 64'(io0.pass), 64'(0));
        chk("reset err_count", 64'(io0.err_count), 64'(0));
        chk("reset dut_a", 64'(io0.dut_a), 64'(0));
        chk("reset lat2 done", 64'(io2.done), 64'(0));
        reset = 1'b0;
        tick();

        // Empty run finishes on the start edge without ever driving the ALU.
        io0.num_vectors = '0;
        io0.start = 1'b1;
        tick();
        io0.start = 1'b0;
        chk("empty done", 64'(io0.done), 64'(1));
        chk("empty pass", 64'(io0.pass), 64'(1));
        chk("empty err_count", 64'(io0.err_count), 64'(0));
        chk("empty dut_f", 64'(io0.dut_f), 64'(0));
        chk("empty dut_a", 64'(io0.dut_a), 64'(0));
        chk("empty dut_b", 64'(io0.dut_b), 64'(0));

        for (int i = 0; i < 4; i++) wr(i, base[i], 1'b1);
        for (int k = 0; k < 5; k++) runSc($sformatf("sc%0d", k), sc[k], 1'b1);

        // Latency-2 instance, with a second start (different count) mid-run that must be ignored.
        io2.num_vectors = 6'd4;
        io2.start = 1'b1;
        tick();
        io2.start = 1'b0;
        cyc = 0;
        while (!io2.done && cyc < 300) begin
            io2.start = (cyc == 3);
            io2.num_vectors = (cyc == 3) ? 6'd1 : 6'd4;
            tick();
            cyc++;
        end
        io2.start = 1'b0;
        chk("lat2 cycles", 64'(cyc), 64'(16));
        chk("lat2 pass", 64'(io2.pass), 64'(1));
        chk("lat2 err_count", 64'(io2.err_count), 64'(0));
        chk("lat2 cur_index", 64'(io2.cur_index), 64'(3));

        // Reset in cycle 5 of a failing run, then rerun from retained memory.
        loadSet(0, -1);
        io0.num_vectors = 6'd4;
        io0.start = 1'b1;
        tick();
        io0.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", 64'(io0.busy), 64'(0));
        chk("abort done", 64'(io0.done), 64'(0));
        chk("abort err_count", 64'(io0.err_count), 64'(0));
        chk("abort cur_index", 64'(io0.cur_index), 64'(0));
        chk("abort dut_a", 64'(io0.dut_a), 64'(0));
        chk("abort dut_f", 64'(io0.dut_f), 64'(0));
        runSc("rerun", sc[3], 1'b0);

        // Full memory of wrong vectors with an over-range count.
        for (int i = 0; i < 32; i++) begin
            tv_t v;
            v = '{3'd2, 32'(i), 32'd1, 32'(i + 2), 1'b0};
            wr(i, v, 1'b0);
        end
        runSc("clamp", sc[5], 1'b0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
